vproc_vregwr_merge: RTL and testbench

- Sits directly downstream of the result-packing stage and upstream of the vector register file write port.
- Each packed beat is either a full-width result or a narrowed result that fills only the lower half of the beat.
- Narrowed beats are merged pairwise into one full OP_W register write. Full-width beats pass through.
- One registered output entry with valid/ready backpressure.

---
 rtl/vproc_vregwr_merge.sv | 141 ++++++++++++++
 tb/tb_vproc_vregwr_merge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_vregwr_merge.sv
// Merges pairs of narrowed (lower-half) result beats into single full-width vector
// register writes; full-width beats pass straight through a one-entry output register.
module vproc_vregwr_merge #(
  parameter int unsigned OP_W   = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk_i,
  input  logic                sync_rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [OP_W-1:0]     in_vd_i,
  input  logic [OP_W/8-1:0]   in_vdmsk_i,
  input  logic                in_narrow_i,
  input  logic                in_last_i,
  input  logic [ADDR_W-1:0]   in_addr_i,
  output logic                wr_valid_o,
  input  logic                wr_ready_i,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [OP_W-1:0]     wr_data_o,
  output logic [OP_W/8-1:0]   wr_mask_o
);

  localparam int unsigned HW  = OP_W / 2;
  localparam int unsigned MW  = OP_W / 8;
  localparam int unsigned HMW = OP_W / 16;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  logic [0:0]        state_q,     state_d;
  logic [HW-1:0]     buf_data_q,  buf_data_d;
  logic [HMW-1:0]    buf_mask_q,  buf_mask_d;
  logic [ADDR_W-1:0] buf_addr_q,  buf_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [OP_W-1:0]   out_data_q,  out_data_d;
  logic [MW-1:0]     out_mask_q,  out_mask_d;

  logic              out_free;
  logic              wide_blocked;
  logic              in_ready;
  logic              accept;
  logic [HW-1:0]     in_lo_data;
  logic [HMW-1:0]    in_lo_mask;

  always_comb begin
    out_free     = ~out_valid_q | wr_ready_i;
    // A full-width beat may not overtake a buffered half; it waits while the half is flushed.
    wide_blocked = (state_q == ST_HALF) & in_valid_i & ~in_narrow_i;
    in_ready     = out_free & ~wide_blocked;
    accept       = in_valid_i & in_ready;
    // Only the lower halves of a narrow beat are ever looked at, so X upper bits stay contained.
    in_lo_data   = in_vd_i[HW-1:0];
    in_lo_mask   = in_vdmsk_i[HMW-1:0];

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_mask_d  = buf_mask_q;
    buf_addr_d  = buf_addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;

    if (out_valid_q & wr_ready_i) begin
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      out_data_d  = '0;
      out_mask_d  = '0;
    end

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          if (!in_narrow_i) begin
            out_valid_d = 1'b1;
            out_addr_d  = in_addr_i;
            out_data_d  = in_vd_i;
            out_mask_d  = in_vdmsk_i;
          end else if (in_last_i) begin
            out_valid_d = 1'b1;
            out_addr_d  = in_addr_i;
            out_data_d  = {{HW{1'b0}}, in_lo_data};
            out_mask_d  = {{(MW-HMW){1'b0}}, in_lo_mask};
          end else begin
            buf_data_d  = in_lo_data;
            buf_mask_d  = in_lo_mask;
            buf_addr_d  = in_addr_i;
            state_d     = ST_HALF;
          end
        end
      end
      default: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_addr_d  = buf_addr_q;
          out_data_d  = {in_lo_data, buf_data_q};
          out_mask_d  = {in_lo_mask, buf_mask_q};
          state_d     = ST_EMPTY;
        end else if (wide_blocked && out_free) begin
          out_valid_d = 1'b1;
          out_addr_d  = buf_addr_q;
          out_data_d  = {{HW{1'b0}}, buf_data_q};
          out_mask_d  = {{(MW-HMW){1'b0}}, buf_mask_q};
          state_d     = ST_EMPTY;
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q     <= ST_EMPTY;
      buf_data_q  <= '0;
      buf_mask_q  <= '0;
      buf_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_mask_q  <= buf_mask_d;
      buf_addr_q  <= buf_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
    end
  end

  assign in_ready_o = in_ready;
  assign wr_valid_o = out_valid_q;
  assign wr_addr_o  = out_addr_q;
  assign wr_data_o  = out_data_q;
  assign wr_mask_o  = out_mask_q;

endmodule

// File: tb/tb_vproc_vregwr_merge.sv
// Self-checking bench for vproc_vregwr_merge: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_vproc_vregwr_merge;

  localparam int OP_W   = 64;
  localparam int ADDR_W = 5;
  localparam int MW     = OP_W / 8;
  localparam int HW     = OP_W / 2;
  localparam int HMW    = OP_W / 16;

  logic              clk = 1'b0;
  logic              sync_rst;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_vd;
  logic [MW-1:0]     in_vdmsk;
  logic              in_narrow;
  logic              in_last;
  logic [ADDR_W-1:0] in_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [OP_W-1:0]   wr_data;
  logic [MW-1:0]     wr_mask;

  always #5 clk = ~clk;

  vproc_vregwr_merge #(.OP_W(OP_W), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .sync_rst_i (sync_rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_vd_i    (in_vd),
    .in_vdmsk_i (in_vdmsk),
    .in_narrow_i(in_narrow),
    .in_last_i  (in_last),
    .in_addr_i  (in_addr),
    .wr_valid_o (wr_valid),
    .wr_ready_i (wr_ready),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .wr_mask_o  (wr_mask)
  );

  int checks   = 0;
  int failures = 0;
  int writes   = 0;

  // Behavioural model: a possibly-held half beat and the pending register write.
  bit                m_half;
  logic [HW-1:0]     m_hd;
  logic [HMW-1:0]    m_hm;
  logic [ADDR_W-1:0] m_ha;
  bit                m_v;
  logic [OP_W-1:0]   m_d;
  logic [MW-1:0]     m_m;
  logic [ADDR_W-1:0] m_a;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [OP_W-1:0] vd, input logic [MW-1:0] msk,
                       input bit narrow, input bit last, input logic [ADDR_W-1:0] addr,
                       input bit wrdy, input bit rst);
    in_valid  = v;
    in_vd     = vd;
    in_vdmsk  = msk;
    in_narrow = narrow;
    in_last   = last;
    in_addr   = addr;
    wr_ready  = wrdy;
    sync_rst  = rst;
  endtask

  task automatic idle(input bit wrdy);
    drive(1'b0, 64'(0), 8'h00, 1'b0, 1'b0, 5'd0, wrdy, 1'b0);
  endtask

  // Compare DUT with model, then advance both across one rising edge.
  task automatic tick();
    bit exp_ready, acc, room;
    #1;
    room      = !m_v || wr_ready;
    exp_ready = room && !(m_half && in_valid && !in_narrow);
    check("in_ready", in_ready, exp_ready);
    check("wr_valid", wr_valid, m_v);
    if (m_v) begin
      check("wr_data", wr_data, m_d);
      check("wr_mask", wr_mask, m_m);
      check("wr_addr", wr_addr, m_a);
    end
    acc = in_valid && exp_ready;
    @(posedge clk);
    if (sync_rst) begin
      m_half = 0; m_v = 0; m_d = '0; m_m = '0; m_a = '0;
    end else begin
      if (m_v && wr_ready) begin
        writes++;
        m_v = 0;
      end
      if (!m_half) begin
        if (acc && !in_narrow) begin
          m_v = 1; m_d = in_vd; m_m = in_vdmsk; m_a = in_addr;
        end else if (acc && in_last) begin
          m_v = 1; m_d = OP_W'(in_vd[HW-1:0]); m_m = MW'(in_vdmsk[HMW-1:0]); m_a = in_addr;
        end else if (acc) begin
          m_half = 1; m_hd = in_vd[HW-1:0]; m_hm = in_vdmsk[HMW-1:0]; m_ha = in_addr;
        end
      end else if (acc) begin
        m_v = 1; m_half = 0; m_a = m_ha;
        m_d = (OP_W'(in_vd[HW-1:0]) << HW) | OP_W'(m_hd);
        m_m = (MW'(in_vdmsk[HMW-1:0]) << HMW) | MW'(m_hm);
      end else if (in_valid && !in_narrow && room) begin
        m_v = 1; m_half = 0; m_a = m_ha;
        m_d = OP_W'(m_hd); m_m = MW'(m_hm);
      end
    end
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input bit v, input logic [OP_W-1:0] d,
                            input logic [MW-1:0] m, input logic [ADDR_W-1:0] a);
    check({name, "_valid"}, wr_valid, v);
    if (v) begin
      check({name, "_data"}, wr_data, d);
      check({name, "_mask"}, wr_mask, m);
      check({name, "_addr"}, wr_addr, a);
    end
  endtask

  initial begin
    logic [31:0] junk;
    m_half = 0; m_v = 0; m_d = '0; m_m = '0; m_a = '0; m_hd = '0; m_hm = '0; m_ha = '0;
    drive(1'b0, 64'(0), 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);

    // Reset held two cycles.
    tick(); tick();
    #1;
    check("rst_valid", wr_valid, 1'b0);
    check("rst_data", wr_data, 64'h0);
    check("rst_mask", wr_mask, 8'h00);
    check("rst_addr", wr_addr, 5'd0);
    check("rst_ready", in_ready, 1'b1);
    idle(1'b1);

    // Full-width pass-through.
    drive(1'b1, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick(); idle(1'b1);
    expect_out("pass", 1'b1, 64'h1122334455667788, 8'hFF, 5'd3);

    // Narrow pair with junk upper halves.
    junk = $urandom;
    drive(1'b1, {junk, 32'hAAAABBBB}, 8'h5F, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    check("pair_first_nowrite", wr_valid, 1'b0);
    junk = $urandom;
    drive(1'b1, {junk, 32'hCCCCDDDD}, 8'h93, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    tick(); idle(1'b1);
    expect_out("pair", 1'b1, 64'hCCCCDDDDAAAABBBB, 8'h3F, 5'd7);

    // Single narrow last beat.
    drive(1'b1, {32'hFFFFFFFF, 32'h12345678}, 8'hEF, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    tick(); idle(1'b1);
    expect_out("single", 1'b1, 64'h0000000012345678, 8'h0F, 5'd2);
    tick();

    // Backpressure: output held, pending beat stalled 5 cycles, then accepted once.
    drive(1'b1, 64'hA5A5A5A5_00000001, 8'hF0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h5A5A5A5A_00000002, 8'h0F, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", in_ready, 1'b0);
      tick();
      expect_out("bp_hold", 1'b1, 64'hA5A5A5A5_00000001, 8'hF0, 5'd1);
    end
    wr_ready = 1'b1;
    tick(); idle(1'b1);
    expect_out("bp_release", 1'b1, 64'h5A5A5A5A_00000002, 8'h0F, 5'd5);
    tick();
    check("bp_no_dup", wr_valid, 1'b0);

    // Wide beat arriving behind a held half.
    drive(1'b1, {32'hDEADDEAD, 32'h0000BEEF}, 8'hC3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    check("flush_ready", in_ready, 1'b0);
    tick();
    expect_out("flush", 1'b1, 64'h000000000000BEEF, 8'h03, 5'd4);
    tick(); idle(1'b1);
    expect_out("after_flush", 1'b1, 64'h0123456789ABCDEF, 8'hFF, 5'd6);
    tick();

    // Same, but reset discards the held half.
    drive(1'b1, {32'hDEADDEAD, 32'h0000BEEF}, 8'hC3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    drive(1'b0, 64'(0), 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    check("rst_half_ready", in_ready, 1'b1);
    tick(); idle(1'b1);
    expect_out("rst_half", 1'b1, 64'h0123456789ABCDEF, 8'hFF, 5'd6);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0,
            {$urandom, $urandom},
            8'($urandom),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0,
            5'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 99) == 0);
      tick();
    end
    idle(1'b1);
    tick(); tick();
    check("drained", wr_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
